// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock
//
// Computes quotient and remainder of two WIDTH-bit operands for DIV (signed)
// and DIVU (unsigned). Results are held until the next accepted start.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active-low
//   start      request, sampled only in IDLE
//   sign_mode  1 = signed, 0 = unsigned; captured with start
//   A, B       dividend / divisor; captured with start
//   busy       high while the divide is in CALC or FIX
//   done       one-cycle pulse when Quotient/Remainder are valid
//   Quotient   registered quotient
//   Remainder  registered remainder
//   DivZero    registered; last accepted op had B == 0

module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] rem;      // partial remainder
   logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs;      // divisor magnitude
   logic [WIDTH-1:0] a_cap;    // raw dividend, returned as remainder on divide by zero
   logic [CW-1:0]    cnt;
   logic             neg_q;
   logic             neg_r;
   logic             dz;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted_rem;
   logic [WIDTH:0]   trial;

   // Magnitudes are taken only in signed mode; the most negative value maps
   // to 2^(WIDTH-1), which is still correct as an unsigned magnitude.
   assign a_neg = sign_mode & A[WIDTH-1];
   assign b_neg = sign_mode & B[WIDTH-1];
   assign abs_a = a_neg ? (~A + 1'b1) : A;
   assign abs_b = b_neg ? (~B + 1'b1) : B;

   // rem < dvs always holds, so the shifted value fits in WIDTH+1 bits and
   // the trial's top bit is a reliable borrow/sign indicator.
   assign shifted_rem = {rem, dvd[WIDTH-1]};
   assign trial       = shifted_rem - {1'b0, dvs};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = (B == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_nx = FIX;
            end
         end
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CALC:    busy = 1'b1;
         FIX:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         a_cap     <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz        <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivZero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_cap <= A;
                  dvd   <= abs_a;
                  dvs   <= abs_b;
                  rem   <= '0;
                  cnt   <= CNT_MAX;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  dz    <= (B == '0);
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted_rem[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
               end
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               if (dz) begin
                  Quotient  <= '1;
                  Remainder <= a_cap;
                  DivZero   <= 1'b1;
               end else begin
                  Quotient  <= neg_q ? (~dvd + 1'b1) : dvd;
                  Remainder <= neg_r ? (~rem + 1'b1) : rem;
                  DivZero   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider

module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sign_mode;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] Quotient;
   logic [W-1:0] Remainder;
   logic         DivZero;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sign_mode (sign_mode),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivZero   (DivZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, truncating division, remainder
   // takes the dividend's sign.
   task automatic model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      longint x, y, qq, rr;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
         if (sm) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
         end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
         end
         qq = x / y;
         rr = x % y;
         q  = qq[W-1:0];
         r  = rr[W-1:0];
         dz = 1'b0;
      end
   endtask

   // Issues one op from IDLE, checks latency, busy span, results, done pulse width.
   task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
      logic [W-1:0] eq, er;
      logic         edz;
      int           n;
      logic         busy_ok;
      model(sm, a, b, eq, er, edz);
      @(negedge clk);
      start = 1'b1; sign_mode = sm; A = a; B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // operands are free to change after acceptance
      A = $urandom; B = $urandom; sign_mode = 1'($urandom);
      n = 0;
      busy_ok = busy;
      while (!done && n < W + 8) begin
         @(negedge clk);
         n++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      chk({tag, " latency"}, 64'(n), edz ? 64'd1 : 64'(W + 1));
      chk({tag, " busy_span"}, 64'(busy_ok), 64'd1);
      chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
      chk({tag, " Q"}, 64'(Quotient), 64'(eq));
      chk({tag, " R"}, 64'(Remainder), 64'(er));
      chk({tag, " DZ"}, 64'(DivZero), 64'(edz));
      @(negedge clk);
      chk({tag, " done_pulse"}, 64'(done), 64'd0);
      chk({tag, " Q_hold"}, 64'(Quotient), 64'(eq));
   endtask

   initial begin
      logic [W-1:0] ra, rb, eq, er;
      logic         edz;
      int           n;
      logic         seen;

      rst_n = 1'b0; start = 1'b0; sign_mode = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, DivZero, Quotient, Remainder}, 64'd0);
      rst_n = 1'b1;

      // directed cases
      run_op(1'b0, 32'd100,        32'd7,        "u100_7");
      run_op(1'b1, 32'hFFFFFF9C,   32'd7,        "s-100_7");
      run_op(1'b1, 32'd100,        32'hFFFFFFF9, "s100_-7");
      run_op(1'b0, 32'hFFFFFFFF,   32'd2,        "uFFFF_2");
      run_op(1'b1, 32'hFFFFFFFF,   32'd2,        "s-1_2");
      run_op(1'b0, 32'd5,          32'd0,        "u5_0");
      run_op(1'b1, 32'd5,          32'd0,        "s5_0");
      run_op(1'b0, 32'd9,          32'd3,        "u9_3");
      run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, "s_ovf");
      run_op(1'b1, 32'h80000000,   32'd0,        "s_min_0");

      // start held high: one IDLE cycle between done and next acceptance
      @(negedge clk);
      start = 1'b1; sign_mode = 1'b0; A = 32'd1000; B = 32'd3;
      n = 0;
      while (!done && n < W + 8) begin @(negedge clk); n++; end
      chk("held_first_done", 64'(done), 64'd1);
      @(negedge clk);
      chk("held_idle_gap", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      chk("held_reaccept", 64'(busy), 64'd1);
      n = 0;
      while (!done && n < W + 8) begin @(negedge clk); n++; end
      start = 1'b0;
      chk("held_second_lat", 64'(n), 64'(W + 1));
      chk("held_second_Q", 64'(Quotient), 64'd333);
      chk("held_second_R", 64'(Remainder), 64'd1);

      // asynchronous reset mid-CALC after a divide-by-zero left nonzero outputs
      run_op(1'b0, 32'd77, 32'd0, "pre_reset");
      @(negedge clk);
      start = 1'b1; sign_mode = 1'b0; A = 32'd1000; B = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {busy, done, DivZero, Quotient, Remainder}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (W + 5) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no_done_after_reset", 64'(seen), 64'd0);
      run_op(1'b1, 32'hFFFFFC18, 32'd7, "post_reset");

      // randomized ops against the reference
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 32'h80000000;
            1:       ra = 32'($urandom_range(0, 1000));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = $urandom_range(0, 1) ? 32'd1 : 32'hFFFFFFFF;
            2:       rb = 32'($urandom_range(1, 15));
            3:       rb = ~32'($urandom_range(0, 15));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         model(1'b0, ra, rb, eq, er, edz);
         run_op(1'($urandom), ra, rb, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
